// File: rtl/comparator_bist.sv
// Exhaustive A/B stimulus generator and response checker for a WIDTH-bit magnitude comparator.
// Each vector is held SETTLE+1 cycles. The response is sampled on the last edge of that window.
module comparator_bist #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  input  logic               A_gt_B,
  input  logic               A_eq_B,
  input  logic               A_lt_B,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               first_err_valid,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b
);

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [SW-1:0]      r_settle;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic [2*WIDTH:0]   r_err_count;
  logic               r_fe_valid;
  logic [WIDTH-1:0]   r_fe_a;
  logic [WIDTH-1:0]   r_fe_b;

  logic               w_sample;
  logic               w_fail;
  logic               w_last;
  logic [2:0]         w_expect;

  assign w_sample = (r_state == S_DRIVE) && (r_settle == '0);
  assign w_expect = {r_a > r_b, r_a == r_b, r_a < r_b};
  // A non-one-hot response always differs from the one-hot expectation.
  assign w_fail   = {A_gt_B, A_eq_B, A_lt_B} != w_expect;
  assign w_last   = w_sample && (&r_a) && (&r_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_DRIVE;
      S_DRIVE: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_settle    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_fe_valid  <= 1'b0;
      r_fe_a      <= '0;
      r_fe_b      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a         <= '0;
            r_b         <= '0;
            r_settle    <= SETTLE_LD;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fe_valid  <= 1'b0;
            r_fe_a      <= '0;
            r_fe_b      <= '0;
          end
        end
        S_DRIVE: begin
          if (!w_sample) begin
            r_settle <= r_settle - 1'b1;
          end else begin
            r_settle <= SETTLE_LD;
            if (w_fail) begin
              if (!(&r_err_count)) r_err_count <= r_err_count + 1'b1;
              if (!r_fe_valid) begin
                r_fe_valid <= 1'b1;
                r_fe_a     <= r_a;
                r_fe_b     <= r_b;
              end
            end
            // Final vector stays on the bus after the run ends.
            if (w_last) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
              r_pass <= (r_err_count == '0) && !w_fail;
            end else begin
              r_b <= r_b + 1'b1;
              if (&r_b) r_a <= r_a + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign A               = r_a;
  assign B               = r_b;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign first_err_valid = r_fe_valid;
  assign first_err_a     = r_fe_a;
  assign first_err_b     = r_fe_b;

endmodule

// File: tb/tb_comparator_bist.sv
// Directed bench for comparator_bist (WIDTH=2, SETTLE=1) with a behavioural CUT whose fault mode is selectable.
module tb_comparator_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] A, B;
  logic       cut_gt, cut_eq, cut_lt;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic       first_err_valid;
  logic [1:0] first_err_a, first_err_b;

  int mode = 0;  // 0 good, 1 eq stuck 0, 2 gt/lt swapped, 3 all ones
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      0:       {cut_gt, cut_eq, cut_lt} = {A > B, A == B, A < B};
      1:       {cut_gt, cut_eq, cut_lt} = {A > B, 1'b0, A < B};
      2:       {cut_gt, cut_eq, cut_lt} = {A < B, A == B, A > B};
      default: {cut_gt, cut_eq, cut_lt} = 3'b111;
    endcase
  end

  comparator_bist #(.WIDTH(2), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(A), .B(B),
    .A_gt_B(cut_gt), .A_eq_B(cut_eq), .A_lt_B(cut_lt),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_a(first_err_a), .first_err_b(first_err_b)
  );

  // Pulses start for one edge, then watches 40 cycles counting busy and done.
  task automatic run_once(output int bcyc, output int dcnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcyc = 0;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) bcyc++;
      if (done) dcnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({A, B, busy, done, pass, err_count, first_err_valid, first_err_a, first_err_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got A=%0d B=%0d busy=%0b done=%0b pass=%0b err=%0d fev=%0b, expected all 0",
               A, B, busy, done, pass, err_count, first_err_valid);
    end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_good_cut();
    int dcnt = 0;
    mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (busy !== 1'b1 || A !== 2'((k / 2) >> 2) || B !== 2'((k / 2) & 3)) begin
        errors++;
        $display("FAIL walk_k%0d: got busy=%0b A=%0d B=%0d expected busy=1 A=%0d B=%0d",
                 k, busy, A, B, (k / 2) >> 2, (k / 2) & 3);
      end
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || A !== 2'd3 || B !== 2'd3) begin
      errors++;
      $display("FAIL end_edge: got busy=%0b done=%0b A=%0d B=%0d expected busy=0 done=1 A=3 B=3", busy, done, A, B);
    end
    dcnt += done ? 1 : 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    checks++;
    if (dcnt != 1) begin errors++; $display("FAIL good_done_count: got %0d expected 1", dcnt); end
    checks++;
    if (pass !== 1'b1 || err_count !== 5'd0 || first_err_valid !== 1'b0 || A !== 2'd3 || B !== 2'd3) begin
      errors++;
      $display("FAIL good_results: got pass=%0b err=%0d fev=%0b A=%0d B=%0d expected pass=1 err=0 fev=0 A=3 B=3",
               pass, err_count, first_err_valid, A, B);
    end
  endtask

  task automatic test_fault(input int m, input int exp_err, input int exp_fa, input int exp_fb);
    int bcyc, dcnt;
    mode = m;
    run_once(bcyc, dcnt);
    checks++;
    if (bcyc != 32 || dcnt != 1) begin
      errors++;
      $display("FAIL fault%0d_timing: got busy=%0d done=%0d expected 32 and 1", m, bcyc, dcnt);
    end
    checks++;
    if (err_count !== 5'(exp_err) || pass !== 1'b0) begin
      errors++;
      $display("FAIL fault%0d_count: got err=%0d pass=%0b expected err=%0d pass=0", m, err_count, pass, exp_err);
    end
    checks++;
    if (first_err_valid !== 1'b1 || first_err_a !== 2'(exp_fa) || first_err_b !== 2'(exp_fb)) begin
      errors++;
      $display("FAIL fault%0d_first: got v=%0b a=%0d b=%0d expected v=1 a=%0d b=%0d",
               m, first_err_valid, first_err_a, first_err_b, exp_fa, exp_fb);
    end
  endtask

  task automatic test_start_while_busy();
    int bcyc, dcnt;
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 10) start = 1'b1;
      @(posedge clk); #1;
      if (k == 11) begin
        checks++;
        if (busy !== 1'b1 || A !== 2'd1 || B !== 2'd1) begin
          errors++;
          $display("FAIL restart_midrun: got busy=%0b A=%0d B=%0d expected busy=1 A=1 B=1", busy, A, B);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || err_count !== 5'd4) begin
      errors++;
      $display("FAIL restart_end: got busy=%0b done=%0b err=%0d expected 0 1 4", busy, done, err_count);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err_count !== 5'd4 || pass !== 1'b0) begin
      errors++;
      $display("FAIL restart_done_ignored: got busy=%0b done=%0b err=%0d pass=%0b expected 0 0 4 0",
               busy, done, err_count, pass);
    end
    @(posedge clk); #1;
    start = 1'b0;
    mode = 0;
    checks++;
    if (busy !== 1'b1 || err_count !== 5'd0 || first_err_valid !== 1'b0 || A !== 2'd0 || B !== 2'd0) begin
      errors++;
      $display("FAIL restart_new_run: got busy=%0b err=%0d fev=%0b A=%0d B=%0d expected 1 0 0 0 0",
               busy, err_count, first_err_valid, A, B);
    end
    bcyc = 1;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (busy) bcyc++;
      if (done) dcnt++;
    end
    checks++;
    if (bcyc != 32 || dcnt != 1 || pass !== 1'b1) begin
      errors++;
      $display("FAIL restart_second_run: got busy=%0d done=%0d pass=%0b expected 32 1 1", bcyc, dcnt, pass);
    end
  endtask

  task automatic test_reset_mid_run();
    int bcyc, dcnt;
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin @(posedge clk); #1; end
    checks++;
    if (A !== 2'd1 || B !== 2'd1 || err_count !== 5'd1) begin
      errors++;
      $display("FAIL rstmid_pre: got A=%0d B=%0d err=%0d expected 1 1 1", A, B, err_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({A, B, busy, done, pass, err_count, first_err_valid, first_err_a, first_err_b} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got A=%0d B=%0d busy=%0b err=%0d fev=%0b expected all 0",
               A, B, busy, err_count, first_err_valid);
    end
    #2 rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin @(posedge clk); #1; if (done || busy) dcnt++; end
    checks++;
    if (dcnt != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", dcnt); end
    mode = 0;
    run_once(bcyc, dcnt);
    checks++;
    if (bcyc != 32 || dcnt != 1 || pass !== 1'b1 || err_count !== 5'd0) begin
      errors++;
      $display("FAIL rstmid_rerun: got busy=%0d done=%0d pass=%0b err=%0d expected 32 1 1 0",
               bcyc, dcnt, pass, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_good_cut();
    test_fault(1, 4, 0, 0);
    test_fault(2, 12, 0, 1);
    test_fault(3, 16, 0, 0);
    test_start_while_busy();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comparator_bist.md
Name: comparator_bist

Overview:
- Synthesizable built-in self-test sequencer for a WIDTH-bit magnitude comparator: the stimulus-and-check end of the comparator interface.
- Drives every A/B operand pair exhaustively to a comparator under test (CUT). Samples its A_gt_B / A_eq_B / A_lt_B responses and checks them against an internal golden relation and a one-hot rule.
- Reports pass/fail, error count and first failing vector.
- Sits beside comparator instances for power-on or on-demand self-test.

Parameters:
- WIDTH, 2, operand width in bits; vector space is 2^(2*WIDTH).
- SETTLE, 1, extra cycles each vector is held before its response is sampled (≥0).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a test run; sampled only in IDLE.
- A  output  WIDTH  operand A to CUT, registered.
- B  output  WIDTH  operand B to CUT, registered.
- A_gt_B  input  1  CUT response.
- A_eq_B  input  1  CUT response.
- A_lt_B  input  1  CUT response.
- busy  output  1  high while vectors are being applied.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  high when the last run had zero errors; held until the next accepted start.
- err_count  output  2*WIDTH+1  number of failing vectors in the last run; saturates at all-ones.
- first_err_valid  output  1  at least one failure recorded.
- first_err_a  output  WIDTH  A of the first failing vector.
- first_err_b  output  WIDTH  B of the first failing vector.

Behaviour:
- Reset (async, rst_n=0): state IDLE; A, B, busy, done, pass, err_count, first_err_valid, first_err_a, first_err_b all 0; settle counter 0.
- Reset mid-run: abandons the run immediately; no done pulse; results are cleared.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - On an edge with start=1: go to DRIVE.
  - On that same edge: A=0, B=0, busy=1, and pass, err_count, first_err_* are cleared.
  - With start=0: stay in IDLE and hold all results.
- DRIVE:
  - Each vector is held for SETTLE+1 cycles.
  - The CUT response is sampled at the last rising edge of that window.
  - At the sampling edge, expected values are computed: gt=(A>B), eq=(A==B), lt=(A<B), unsigned.
  - A vector fails if any response bit differs from expected. This also covers the case where the response is not one-hot.
  - On a failure: err_count increments, saturating.
  - On the first failure: first_err_a/b capture A/B and first_err_valid is set.
  - Ordering: B increments on each sampling edge. When B wraps from all-ones to 0, A increments (A outer loop, B inner loop).
  - After sampling A=B=all-ones, go to DONE on the same edge. busy drops to 0 there and done rises to 1.
- DONE:
  - Lasts exactly one cycle with done=1.
  - pass = (err_count==0), registered at entry to DONE. The last vector's error is included.
  - Then go to IDLE. A and B hold their last value.
  - start asserted while in DONE is ignored; it is taken on the following IDLE cycle.
- start while busy: ignored with no effect.
- Run length: the first sampling edge is SETTLE+1 cycles after the start edge. busy is high for exactly 2^(2*WIDTH)*(SETTLE+1) cycles. Default: 32 cycles.
- Width rules:
  - err_count cannot overflow at the maximum of 2^(2*WIDTH); saturation logic is still required.
  - The A/B counters wrap modulo 2^WIDTH.
- The CUT is assumed combinational. Responses are sampled directly with no synchronizer.

Test Plan:
- Correct 2-bit comparator attached, start pulsed 1 cycle → busy high for 32 cycles; A/B walk 00/00,00/01…11/11 (each held 2 cycles); done pulses once; pass=1, err_count=0, first_err_valid=0.
- CUT with A_eq_B stuck at 0 → err_count=4, pass=0, first_err_a=00, first_err_b=00.
- CUT with GT and LT swapped → err_count=12, first_err_a=00, first_err_b=01.
- CUT driving all three responses to 1 → err_count=16 (one-hot violations), pass=0.
- start re-pulsed at cycle 10 of a run, and held high through DONE → the run is unaffected and ends at cycle 32; a new run begins on the first IDLE cycle; results cleared at that start edge.
- rst_n pulsed low during vector A=01, B=01 → all outputs 0 asynchronously, no done pulse; a subsequent start gives a full 32-cycle run with correct results.
